// File: rtl/screen_painter_pkg.sv
// screen_pkg: mode encodings, default frame size and colour constants shared by the painter.
package screen_pkg;
    localparam logic [1:0] MODE_FILL  = 2'd0;
    localparam logic [1:0] MODE_IMAGE = 2'd1;
    localparam logic [1:0] MODE_SUBST = 2'd2;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam logic [2:0] BLACK = 3'd0;
    localparam logic [2:0] RED   = 3'b100;
endpackage

// File: rtl/screen_painter_delay.sv
// pixel_delay_line: fixed-depth shift register that aligns issued pixels with ROM data.
module pixel_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] stage_q [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end
    assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/screen_painter.sv
// screen_painter: raster-sweeps a WIDTH x HEIGHT frame, emitting plot strobes with
// colour from a latched fill value, an external ROM, or the ROM with key substitution.
module screen_painter
    import screen_pkg::*;
#(
    parameter int WIDTH       = SCREEN_W,
    parameter int HEIGHT      = SCREEN_H,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int ADDR_W      = 15,
    parameter int COLOUR_W    = 3,
    parameter int ROM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [COLOUR_W-1:0] fill_colour,
    input  logic [COLOUR_W-1:0] key_colour,
    input  logic [COLOUR_W-1:0] subst_colour,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic [COLOUR_W-1:0] fill_q, fill_d, key_q, key_d, subst_q, subst_d, colour_q;
    logic [COLOUR_W-1:0] sel;
    logic                row_end, last;
    logic [X_W-1:0]      x_dl;
    logic [Y_W-1:0]      y_dl;
    logic                v_dl;

    assign row_end = x_q == X_W'(WIDTH - 1);
    assign last    = row_end && y_q == Y_W'(HEIGHT - 1);

    // Counters freeze on the last pixel so the delay line keeps presenting it, which
    // makes x/y hold their final values once plotting stops.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        key_d   = key_q;
        subst_d = subst_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RUN;
                x_d     = '0;
                y_d     = '0;
                addr_d  = '0;
                mode_d  = mode;
                fill_d  = fill_colour;
                key_d   = key_colour;
                subst_d = subst_colour;
            end
            S_RUN: if (last) begin
                state_d = S_DRAIN;
                cnt_d   = '0;
            end else begin
                x_d    = row_end ? '0 : x_q + 1'b1;
                y_d    = row_end ? y_q + 1'b1 : y_q;
                addr_d = addr_q + 1'b1;
            end
            S_DRAIN: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == 3'(ROM_LATENCY - 1) ? S_DONE : S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            mode_q   <= MODE_FILL;
            fill_q   <= '0;
            key_q    <= '0;
            subst_q  <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            fill_q   <= fill_d;
            key_q    <= key_d;
            subst_q  <= subst_d;
            colour_q <= colour;
        end
    end

    pixel_delay_line #(.DEPTH(ROM_LATENCY), .W(X_W + Y_W + 1)) u_align (
        .clk (clk),
        .rst (rst),
        .d_i ({state_q == S_RUN, x_q, y_q}),
        .q_o ({v_dl, x_dl, y_dl})
    );

    assign sel = mode_q == MODE_IMAGE ? rom_data :
                 mode_q == MODE_SUBST ? (rom_data == key_q ? subst_q : rom_data) : fill_q;

    assign plot     = v_dl;
    assign x        = x_dl;
    assign y        = y_dl;
    assign colour   = v_dl ? sel : colour_q;
    assign rom_addr = addr_q;
    assign busy     = state_q == S_RUN || state_q == S_DRAIN;
    assign done     = state_q == S_DONE;
endmodule

// File: tb/tb_screen_painter.sv
// tb_screen_painter: drives three painter instances (4x3 L=1, 4x3 L=2, 160x120 L=1) and
// checks every cycle against a raster/latency model computed from pixel index arithmetic.
module tb_screen_painter;
    localparam int WS[3] = '{4, 4, 160};
    localparam int HS[3] = '{3, 3, 120};
    localparam int LS[3] = '{1, 2, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s[3];
    logic [1:0]  mode = 2'd0;
    logic [2:0]  fc = 3'd0, kc = 3'd0, sc = 3'd0;
    logic [14:0] ra[3];
    logic [2:0]  rd[3];
    logic [7:0]  xo[3];
    logic [6:0]  yo[3];
    logic [2:0]  co[3];
    logic        pl[3], bz[3], dn[3];
    logic [14:0] rp[3][4];
    logic [2:0]  rom_mem[32768];
    logic [7:0]  hx[3];
    logic [6:0]  hy[3];
    logic [2:0]  hc[3];
    int          errs = 0, checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++) rp[i][j] <= (j == 0) ? ra[i] : rp[i][j-1];

    always_comb
        for (int i = 0; i < 3; i++) rd[i] = rom_mem[rp[i][LS[i]-1]];

    screen_painter #(.WIDTH(4), .HEIGHT(3), .ROM_LATENCY(1)) u0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .mode(mode), .fill_colour(fc),
        .key_colour(kc), .subst_colour(sc), .rom_addr(ra[0]), .rom_data(rd[0]),
        .x(xo[0]), .y(yo[0]), .colour(co[0]), .plot(pl[0]), .busy(bz[0]), .done(dn[0]));
    screen_painter #(.WIDTH(4), .HEIGHT(3), .ROM_LATENCY(2)) u1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .mode(mode), .fill_colour(fc),
        .key_colour(kc), .subst_colour(sc), .rom_addr(ra[1]), .rom_data(rd[1]),
        .x(xo[1]), .y(yo[1]), .colour(co[1]), .plot(pl[1]), .busy(bz[1]), .done(dn[1]));
    screen_painter u2 (
        .clk(clk), .rst(rst), .start(start_s[2]), .mode(mode), .fill_colour(fc),
        .key_colour(kc), .subst_colour(sc), .rom_addr(ra[2]), .rom_data(rd[2]),
        .x(xo[2]), .y(yo[2]), .colour(co[2]), .plot(pl[2]), .busy(bz[2]), .done(dn[2]));

    function automatic logic [2:0] ref_col(logic [1:0] m, logic [2:0] f, logic [2:0] k,
                                           logic [2:0] s, logic [2:0] d);
        return m == 2'd1 ? d : m == 2'd2 ? (d == k ? s : d) : f;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset(int i);
        chk("rst_plot", 32'(pl[i]), 0);
        chk("rst_busy", 32'(bz[i]), 0);
        chk("rst_done", 32'(dn[i]), 0);
        chk("rst_x", 32'(xo[i]), 0);
        chk("rst_y", 32'(yo[i]), 0);
        chk("rst_addr", 32'(ra[i]), 0);
        chk("rst_colour", 32'(co[i]), 0);
    endtask

    // Called at a negedge in cycle 0; returns at the negedge of the cycle after done.
    task automatic run_op(int i, logic [1:0] m, logic [2:0] f, logic [2:0] k, logic [2:0] s,
                          bit poke);
        int n = WS[i] * HS[i];
        int l = LS[i];
        int plots = 0, dones = 0;
        mode = m; fc = f; kc = k; sc = s; start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
        for (int c = 1; c <= n + l + 1; c++) begin
            bit ep = c >= 1 + l && c <= n + l;
            int kk = c - 1 - l;
            if (ep) begin
                hx[i] = 8'(kk % WS[i]);
                hy[i] = 7'(kk / WS[i]);
                hc[i] = ref_col(m, f, k, s, rom_mem[kk]);
            end
            chk("plot", 32'(pl[i]), 32'(ep));
            chk("x", 32'(xo[i]), 32'(hx[i]));
            chk("y", 32'(yo[i]), 32'(hy[i]));
            chk("colour", 32'(co[i]), 32'(hc[i]));
            chk("busy", 32'(bz[i]), 32'(c <= n + l));
            chk("done", 32'(dn[i]), 32'(c == n + l + 1));
            if (c <= n + l) chk("rom_addr", 32'(ra[i]), c <= n ? c - 1 : n - 1);
            plots += int'(pl[i]);
            dones += int'(dn[i]);
            if (poke && c == 5) begin
                start_s[i] = 1'b1; mode = ~m; fc = ~f; kc = ~k; sc = ~s;
            end else start_s[i] = 1'b0;
            @(negedge clk);
        end
        chk("plot_count", plots, n);
        chk("done_count", dones, 1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0; hx[i] = '0; hy[i] = '0; hc[i] = '0;
        end
        for (int a = 0; a < 32768; a++) rom_mem[a] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_reset(i);
        rst = 1'b0;
        @(negedge clk);
        run_op(0, 2'd0, 3'd5, 3'd0, 3'd0, 1'b0);
        for (int a = 0; a < 12; a++) rom_mem[a] = 3'(a);
        run_op(1, 2'd1, 3'd0, 3'd0, 3'd0, 1'b0);
        for (int a = 0; a < 12; a++) rom_mem[a] = (a % 2 == 0) ? 3'd4 : 3'd2;
        run_op(1, 2'd2, 3'd1, 3'd4, 3'd0, 1'b0);
        run_op(0, 2'd0, 3'd6, 3'd0, 3'd0, 1'b1);
        run_op(1, 2'd1, 3'd3, 3'd0, 3'd0, 1'b1);
        mode = 2'd0; fc = 3'd7; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset(0);
        for (int i = 0; i < 3; i++) begin
            hx[i] = '0; hy[i] = '0; hc[i] = '0;
        end
        run_op(0, 2'd1, 3'd0, 3'd0, 3'd0, 1'b0);
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 12; a++) rom_mem[a] = 3'($urandom_range(0, 7));
            run_op(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom),
                   3'($urandom), 3'($urandom), 1'($urandom));
        end
        run_op(2, 2'd3, 3'd2, 3'd0, 3'd0, 1'b0);
        chk("big_last_x", 32'(xo[2]), 159);
        chk("big_last_y", 32'(yo[2]), 119);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/screen_painter.md
Name: screen_painter

Overview:
- Parametrised full-screen painter that sweeps every pixel of a WIDTH x HEIGHT frame in raster order.
- Emits x, y, colour and plot strobes to the VGA adapter's write port.
- Colour source is chosen per operation: solid fill, image from an external ROM, or image with key-colour substitution (flash effect).
- Sits between the game controller (start/done handshake) and the VGA adapter; replaces the fixed title/game-over drawer.

Parameters:
- WIDTH, 160, pixels per row
- HEIGHT, 120, rows per frame
- X_W, 8, x coordinate width (must satisfy 2^X_W >= WIDTH)
- Y_W, 7, y coordinate width (must satisfy 2^Y_W >= HEIGHT)
- ADDR_W, 15, ROM address width (must satisfy 2^ADDR_W >= WIDTH*HEIGHT)
- COLOUR_W, 3, colour bits per pixel
- ROM_LATENCY, 1, cycles from rom_addr to valid rom_data (1..4)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  2  0=FILL, 1=IMAGE, 2=SUBST, 3=reserved (treated as FILL); latched at start
- fill_colour  in  COLOUR_W  colour for FILL; latched at start
- key_colour  in  COLOUR_W  colour to replace in SUBST; latched at start
- subst_colour  in  COLOUR_W  replacement colour in SUBST; latched at start
- rom_addr  out  ADDR_W  pixel index y*WIDTH+x of the pixel being fetched
- rom_data  in  COLOUR_W  ROM output, valid ROM_LATENCY cycles after rom_addr
- x  out  X_W  pixel column, aligned with plot
- y  out  Y_W  pixel row, aligned with plot
- colour  out  COLOUR_W  pixel colour, aligned with plot
- plot  out  1  write strobe to the VGA adapter
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FSM goes to IDLE.
  - All outputs go to 0: rom_addr, x, y, colour, plot, busy, done.
  - The pipeline is flushed. Reset mid-sweep aborts the sweep with no further plot.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches mode and the three colour inputs, clears the x/y/address counters, then moves to RUN.
  - start=0: hold.
- RUN:
  - Each cycle, present the current (x, y, address) to the pipeline and to rom_addr, then advance.
  - Advance rule: x increments; at x=WIDTH-1, x wraps to 0 and y increments.
  - Counters are kept separately (no divide or modulo); address increments by 1 each cycle.
  - After issuing pixel (WIDTH-1, HEIGHT-1), address WIDTH*HEIGHT-1, move to DRAIN.
- DRAIN: wait ROM_LATENCY cycles for in-flight pixels to emerge, then go to DONE.
- DONE: done=1 for exactly one cycle, busy falls in the same cycle, then IDLE.
- busy is 1 in RUN and DRAIN, 0 in IDLE and DONE.
- start is ignored whenever the FSM is not in IDLE; no queuing.
- Pipeline:
  - x, y and the issue-valid bit go through a ROM_LATENCY-stage delay line.
  - A pixel issued in cycle t appears on x/y/colour with plot=1 in cycle t+ROM_LATENCY.
  - FILL uses the same latency so output timing is independent of mode.
- Colour selection, applied on the delayed pixel:
  - FILL: colour = latched fill_colour.
  - IMAGE: colour = rom_data.
  - SUBST: colour = subst_colour if rom_data == key_colour, else rom_data.
- Plot count: exactly WIDTH*HEIGHT plot pulses per operation, one per pixel, in raster order, contiguous with no gaps.
- Timing: start accepted in cycle 0 (IDLE) gives first plot in cycle 1+ROM_LATENCY, last plot in cycle WIDTH*HEIGHT+ROM_LATENCY, done in the following cycle.
- The next start can be accepted the cycle after done.
- When plot=0, x/y/colour hold their last values.
- Latched inputs: mode or colour input changes during busy have no effect.

Decomposition:
- Shared package screen_pkg holds:
  - mode encodings: MODE_FILL, MODE_IMAGE, MODE_SUBST
  - default SCREEN_W=160, SCREEN_H=120
  - colour constants: BLACK=0, RED=3'b100
- One natural sub-module: pixel_delay_line, a parametrised depth/width shift register with synchronous reset, used for the x, y and valid alignment.
- The x/y raster counter and the FSM stay inline.

Test Plan:
- WIDTH=4, HEIGHT=3, ROM_LATENCY=1, FILL with fill_colour=5, start at cycle 0:
  - exactly 12 plots in cycles 2..13, in order (0,0),(1,0),(2,0),(3,0),(0,1)..(3,2), all with colour=5.
  - done=1 only in cycle 14; busy=1 in cycles 1..13.
- IMAGE, ROM model returns data=address[2:0], ROM_LATENCY=2:
  - rom_addr sequence is 0..11.
  - plot k has colour = k mod 8 and appears 2 cycles after its address.
  - done occurs in cycle 15.
- SUBST with key_colour=4, subst_colour=0, ROM returns 4 at even addresses and 2 at odd addresses: plotted colours alternate 0,2,0,2...
- Start pulsed at cycle 5 during busy, and mode/fill_colour changed mid-sweep: no second sweep, outputs unchanged, exactly 12 plots, a single done.
- rst=1 asserted at cycle 6 mid-RUN:
  - next cycle: plot=0, busy=0, x=y=rom_addr=0, and no done.
  - a fresh start afterwards produces a full 12-pixel sweep from (0,0).
- mode=3 behaves as FILL. Default parameters, 160x120: exactly 19200 plots, last plot at (159,119) with rom_addr=19199.
